// File: rtl/cpu_pkg.sv
// Shared CPU pipeline definitions: datapath/control widths, ALUC encodings and
// the all-zero bubble control word used when the ID/EX stage is killed.
package cpu_pkg;

  localparam int XLEN   = 32;
  localparam int TD_W   = 5;
  localparam int ALUC_W = 4;

  typedef enum logic [ALUC_W-1:0] {
    ALUC_ADD = 4'h0,
    ALUC_AND = 4'h1,
    ALUC_XOR = 4'h2,
    ALUC_SLL = 4'h3,
    ALUC_SUB = 4'h4,
    ALUC_OR  = 4'h5,
    ALUC_LUI = 4'h6,
    ALUC_SRL = 4'h7,
    ALUC_SRA = 4'hF
  } aluc_e;

  typedef struct packed {
    logic [TD_W-1:0]   td;
    logic              wreg;
    logic              m2reg;
    logic              wmem;
    logic [ALUC_W-1:0] aluc;
    logic              aluimm;
    logic              shift;
  } ctrl_t;

  // A bubble writes nothing and is never a load, so it cannot re-trigger a stall.
  localparam ctrl_t BUBBLE_CTRL = '0;

endpackage

// File: rtl/pipe_dffe.sv
// Pipeline field flop: async active-low reset to zero, enable, and a
// synchronous clear (only effective while enabled) to CLR_VAL.
module pipe_dffe #(
  parameter int           W       = 1,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: sequential state uses non-blocking (<=) so every flop samples
  // pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= clr ? CLR_VAL : d;
    end
  end

endmodule

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with hold > flush > stall > load priority.
// Optional bubble/flush counters are compiled in with macro STALL_CNT_EN.
module id_ex_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              flush,
  input  logic              hold,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [XLEN-1:0]   id_a,
  input  logic [XLEN-1:0]   id_b,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [TD_W-1:0]   id_td,
  input  logic              id_wreg,
  input  logic              id_m2reg,
  input  logic              id_wmem,
  input  logic [ALUC_W-1:0] id_aluc,
  input  logic              id_aluimm,
  input  logic              id_shift,
  output logic              ex_valid,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_a,
  output logic [XLEN-1:0]   ex_b,
  output logic [XLEN-1:0]   ex_imm,
  output logic [TD_W-1:0]   ex_td,
  output logic              ex_wreg,
  output logic              ex_LW,
  output logic              ex_wmem,
  output logic [ALUC_W-1:0] ex_aluc,
  output logic              ex_aluimm,
  output logic              ex_shift,
  output logic [15:0]       stall_cnt,
  output logic [15:0]       flush_cnt
);

  logic en;
  logic kill;

  assign en   = ~hold;
  // Invalid ID slots are squashed exactly like stalls/flushes.
  assign kill = flush | stall | ~id_valid;

  pipe_dffe #(.W(1))    u_valid (.clk, .rst_n, .en, .clr(kill), .d(id_valid), .q(ex_valid));
  pipe_dffe #(.W(XLEN)) u_pc    (.clk, .rst_n, .en, .clr(kill), .d(id_pc),    .q(ex_pc));
  pipe_dffe #(.W(XLEN)) u_a     (.clk, .rst_n, .en, .clr(kill), .d(id_a),     .q(ex_a));
  pipe_dffe #(.W(XLEN)) u_b     (.clk, .rst_n, .en, .clr(kill), .d(id_b),     .q(ex_b));
  pipe_dffe #(.W(XLEN)) u_imm   (.clk, .rst_n, .en, .clr(kill), .d(id_imm),   .q(ex_imm));

  pipe_dffe #(.W(TD_W), .CLR_VAL(BUBBLE_CTRL.td))
    u_td     (.clk, .rst_n, .en, .clr(kill), .d(id_td),     .q(ex_td));
  pipe_dffe #(.W(1), .CLR_VAL(BUBBLE_CTRL.wreg))
    u_wreg   (.clk, .rst_n, .en, .clr(kill), .d(id_wreg),   .q(ex_wreg));
  pipe_dffe #(.W(1), .CLR_VAL(BUBBLE_CTRL.m2reg))
    u_m2reg  (.clk, .rst_n, .en, .clr(kill), .d(id_m2reg),  .q(ex_LW));
  pipe_dffe #(.W(1), .CLR_VAL(BUBBLE_CTRL.wmem))
    u_wmem   (.clk, .rst_n, .en, .clr(kill), .d(id_wmem),   .q(ex_wmem));
  pipe_dffe #(.W(ALUC_W), .CLR_VAL(BUBBLE_CTRL.aluc))
    u_aluc   (.clk, .rst_n, .en, .clr(kill), .d(id_aluc),   .q(ex_aluc));
  pipe_dffe #(.W(1), .CLR_VAL(BUBBLE_CTRL.aluimm))
    u_aluimm (.clk, .rst_n, .en, .clr(kill), .d(id_aluimm), .q(ex_aluimm));
  pipe_dffe #(.W(1), .CLR_VAL(BUBBLE_CTRL.shift))
    u_shift  (.clk, .rst_n, .en, .clr(kill), .d(id_shift),  .q(ex_shift));

`ifdef STALL_CNT_EN
  // A combined stall+flush is one bubble and is counted only as a flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (!hold) begin
      if (flush) begin
        if (flush_cnt != 16'hFFFF) flush_cnt <= flush_cnt + 16'd1;
      end else if (stall) begin
        if (stall_cnt != 16'hFFFF) stall_cnt <= stall_cnt + 16'd1;
      end
    end
  end
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule
